mem_interface: RTL and testbench

Memory interface stage: it holds the MAR and MDR and runs a handshake-based read/write transaction state machine against the external RAM. It consumes `BusMuxOut` to load MAR/MDR. It produces `BusMuxInMDR` (MDR contents) and `address` (MAR contents), which the bus multiplexer gates onto the bus under `MDRout`/`MARout`. Memory may insert any number of wait states; a watchdog aborts transactions that never complete.

---
 rtl/mem_interface.sv | 113 +++++++++++
 tb/tb_mem_interface.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_interface.sv
// MAR/MDR holding stage with a req/ack transaction FSM toward the external RAM.
// Wait states are unbounded from the RAM side; a watchdog aborts a stalled transaction.
module mem_interface #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] BusMuxOut,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] BusMuxInMDR,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] mar_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  req_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;

  // Control outputs are registered next to the state so nothing from the inputs
  // reaches them combinationally; the async reset still drops mem_req at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MARin) mar_q <= BusMuxOut;
          if (MDRin) mdr_q <= BusMuxOut;
          if (MemRead || MemWrite) begin
            state_q <= MemRead ? RD : WR;
            we_q    <= ~MemRead;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        RD, WR: begin
          if (mem_ack) begin
            if (state_q == RD) mdr_q <= mem_rdata;
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address     = mar_q;
  assign BusMuxInMDR = mdr_q;
  assign mem_wdata   = mdr_q;
  assign mem_addr    = mar_q[ADDR_WIDTH-1:0];
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: expected RAM requests and done-time MDR values
// are queued by the stimulus and popped by a negedge monitor that also models the RAM.
module tb_mem_interface;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, MemRead, MemWrite;
  logic [31:0] address, BusMuxInMDR, mem_wdata, mem_rdata;
  logic [8:0]  mem_addr;
  logic        mem_req, mem_we, mem_ack, busy, done, err;

  mem_interface #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .MemRead(MemRead), .MemWrite(MemWrite), .address(address),
    .BusMuxInMDR(BusMuxInMDR), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic        we;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] done_q[$];
  req_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          ack_wait = 1000;
  logic [31:0] rd_val = '0;
  int          req_cnt = 0;
  int          last_len = 0;
  int          done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // RAM model + monitor in one process so request bookkeeping and ack drive agree.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        chk("done_mdr", BusMuxInMDR, done_q.pop_front());
      end
    end
    if (mem_req) begin
      if (req_cnt == 0) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=1 expected=0");
          cur = '{addr: mem_addr, we: mem_we, wdata: mem_wdata};
        end else begin
          cur = req_q.pop_front();
          chk("req_addr", {23'b0, mem_addr}, {23'b0, cur.addr});
          chk("req_we", {31'b0, mem_we}, {31'b0, cur.we});
          chk("req_wdata", mem_wdata, cur.wdata);
        end
      end else begin
        chk("wdata_stable", mem_wdata, cur.wdata);
      end
      mem_ack   = (req_cnt == ack_wait);
      mem_rdata = rd_val;
      req_cnt++;
    end else begin
      if (req_cnt != 0) last_len = req_cnt;
      req_cnt = 0;
      mem_ack = 1'b0;
    end
  end

  task automatic load(input bit m, input bit d, input logic [31:0] v);
    BusMuxOut = v; MARin = m; MDRin = d;
    @(posedge clk); #2;
    MARin = 0; MDRin = 0;
  endtask

  // Returns the number of edges after the accepting edge until busy is seen low.
  task automatic run(input bit rd, input bit wr, input bit noise, input int waits,
                     input logic [31:0] rdv, output int n);
    ack_wait = waits; rd_val = rdv;
    MemRead = rd; MemWrite = wr;
    @(posedge clk); #2;
    MemRead = 0; MemWrite = 0;
    if (noise) begin
      MARin = 1; MDRin = 1; BusMuxOut = 32'h12345678;
    end
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL busy_bound actual=%0d expected<40", n);
    end
    MARin = 0; MDRin = 0;
    @(negedge clk); #1;
  endtask

  int n, d0;

  initial begin
    clr = 1; BusMuxOut = 0; MARin = 0; MDRin = 0; MemRead = 0; MemWrite = 0;
    mem_ack = 0; mem_rdata = 0;
    #12;
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_we", {31'b0, mem_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_addr", address, 0);
    chk("rst_mdr", BusMuxInMDR, 0);
    chk("rst_memaddr", {23'b0, mem_addr}, 0);
    clr = 0;
    @(posedge clk); #2;

    // clr in the middle of a read that never gets acked
    load(1, 0, 32'h0000_0055);
    req_q.push_back('{addr: 9'h055, we: 1'b0, wdata: 32'h0});
    ack_wait = 1000;
    MemRead = 1;
    @(posedge clk); #2;
    MemRead = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_req_high", {31'b0, mem_req}, 1);
    clr = 1;
    #1;
    chk("clr_req", {31'b0, mem_req}, 0);
    chk("clr_busy", {31'b0, busy}, 0);
    chk("clr_done", {31'b0, done}, 0);
    chk("clr_addr", address, 0);
    chk("clr_mdr", BusMuxInMDR, 0);
    chk("clr_memaddr", {23'b0, mem_addr}, 0);
    @(posedge clk); #2;
    clr = 0;
    @(posedge clk); #2;
    chk("clr_err", {31'b0, err}, 0);
    chk("clr_busy2", {31'b0, busy}, 0);

    // zero-wait read
    load(1, 0, 32'h0000_0012);
    req_q.push_back('{addr: 9'h012, we: 1'b0, wdata: 32'h0});
    done_q.push_back(32'hDEADBEEF);
    d0 = done_cnt;
    run(1, 0, 0, 0, 32'hDEADBEEF, n);
    chk("rd0_edges", n, 2);
    chk("rd0_len", last_len, 1);
    chk("rd0_dones", done_cnt - d0, 1);
    chk("rd0_mdr", BusMuxInMDR, 32'hDEADBEEF);

    // write with 3 wait states
    load(1, 0, 32'h0000_01FF);
    load(0, 1, 32'h0000_A5A5);
    req_q.push_back('{addr: 9'h1FF, we: 1'b1, wdata: 32'h0000_A5A5});
    done_q.push_back(32'h0000_A5A5);
    d0 = done_cnt;
    run(0, 1, 0, 3, 32'hFFFF_FFFF, n);
    chk("wr3_edges", n, 5);
    chk("wr3_len", last_len, 4);
    chk("wr3_dones", done_cnt - d0, 1);
    chk("wr3_mdr", BusMuxInMDR, 32'h0000_A5A5);

    // loads attempted during a 2-wait write must be ignored
    load(0, 1, 32'h0000_C3C3);
    req_q.push_back('{addr: 9'h1FF, we: 1'b1, wdata: 32'h0000_C3C3});
    done_q.push_back(32'h0000_C3C3);
    d0 = done_cnt;
    run(0, 1, 1, 2, 32'hFFFF_FFFF, n);
    chk("stab_edges", n, 4);
    chk("stab_len", last_len, 3);
    chk("stab_dones", done_cnt - d0, 1);
    chk("stab_mdr", BusMuxInMDR, 32'h0000_C3C3);
    chk("stab_mar", address, 32'h0000_01FF);

    // MemRead and MemWrite together: read wins
    load(1, 0, 32'h0000_00A0);
    req_q.push_back('{addr: 9'h0A0, we: 1'b0, wdata: 32'h0000_C3C3});
    done_q.push_back(32'h0BADF00D);
    run(1, 1, 0, 1, 32'h0BADF00D, n);
    chk("both_edges", n, 3);
    chk("both_mdr", BusMuxInMDR, 32'h0BADF00D);

    // watchdog timeout
    load(1, 0, 32'h0000_0033);
    req_q.push_back('{addr: 9'h033, we: 1'b0, wdata: 32'h0BADF00D});
    d0 = done_cnt;
    run(1, 0, 0, 1000, 32'h1111_1111, n);
    chk("to_edges", n, 16);
    chk("to_len", last_len, 16);
    chk("to_err", {31'b0, err}, 1);
    chk("to_dones", done_cnt - d0, 0);
    chk("to_mdr", BusMuxInMDR, 32'h0BADF00D);

    // next good read clears err
    req_q.push_back('{addr: 9'h033, we: 1'b0, wdata: 32'h0BADF00D});
    done_q.push_back(32'h600DCAFE);
    run(1, 0, 0, 2, 32'h600DCAFE, n);
    chk("rec_edges", n, 4);
    chk("rec_err", {31'b0, err}, 0);
    chk("rec_mdr", BusMuxInMDR, 32'h600DCAFE);

    chk("left_done_exp", done_q.size(), 0);
    chk("left_req_exp", req_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation bound exceeded");
  end

endmodule
